// File: rtl/ls299.sv
// 74LS299 8-bit universal shift/storage register, tri-state I/O split into in/out/oe; one clk edge to r, outputs combinational from r.
// Define LS299_CEN_EN to add a clock-enable input (cen); without it every rising edge updates.
module ls299 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
`ifdef LS299_CEN_EN
    input  logic             cen,
`endif
    input  logic [1:0]       s,
    input  logic             oe1_n,
    input  logic             oe2_n,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic             io_oe,
    output logic             q0s,
    output logic             q7s
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] r;
    logic             upd;

`ifdef LS299_CEN_EN
    assign upd = cen;
`else
    assign upd = 1'b1;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r <= '0;
        end else if (upd) begin
            case (s)
                2'b01:   r <= {r[MSB-1:0], dsr};
                2'b10:   r <= {dsl, r[MSB:1]};
                2'b11:   r <= io_in;
                default: r <= r;
            endcase
        end
    end

    // Never drive the bus while loading from it, whatever the enables say.
    assign io_oe  = ~oe1_n & ~oe2_n & (s != 2'b11);
    assign io_out = r;
    assign q0s    = r[0];
    assign q7s    = r[MSB];
endmodule
